sprite_palette_bank: RTL and testbench



---
 rtl/sprite_palette_pkg.sv | 39 +++
 rtl/palette_fade_ctrl.sv | 86 ++++++++
 rtl/sprite_palette_bank.sv | 212 +++++++++++++++++++++
 tb/tb_sprite_palette_bank.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_palette_pkg.sv
// ---------------------------------------------------------------------------
// sprite_palette_pkg
//   Shared types and constants for the sprite palette bank.
//   - rgb_t         : packed {r,g,b} colour, 4 bits per channel
//   - DEFAULT_PAL   : contents loaded into bank 0 at reset
//   - fade_state_t  : fade controller states
//   - FADE_MAX      : fade level that corresponds to full black
//   - default_entry : reset value of bank-0 entry idx (0 beyond the table)
// ---------------------------------------------------------------------------
package sprite_palette_pkg;

   localparam int PAL_CW      = 4;
   localparam int DEF_ENTRIES = 8;
   localparam int FADE_MAX    = 16;

   typedef struct packed {
      logic [PAL_CW-1:0] r;
      logic [PAL_CW-1:0] g;
      logic [PAL_CW-1:0] b;
   } rgb_t;

   typedef enum logic {
      IDLE   = 1'b0,
      FADING = 1'b1
   } fade_state_t;

   localparam rgb_t DEFAULT_PAL [DEF_ENTRIES] = '{
      12'h050, 12'hEA2, 12'h860, 12'h090,
      12'h7C0, 12'h420, 12'h000, 12'h5A0
   };

   function automatic rgb_t default_entry(input int unsigned idx);
      rgb_t e;
      e = '0;
      if (idx < DEF_ENTRIES) e = DEFAULT_PAL[idx[2:0]];
      return e;
   endfunction

endpackage

// File: rtl/palette_fade_ctrl.sv
// ---------------------------------------------------------------------------
// palette_fade_ctrl
//   Frame-synchronous fade engine. Holds the fade level (0 = full colour,
//   FADE_MAX = black) and steps it by one every FADE_PERIOD frame ticks
//   toward the target selected by the last fade_start.
// Ports:
//   clk_i         system clock
//   rst_i         synchronous active-high reset
//   frame_tick_i  one-cycle pulse per frame
//   fade_start_i  pulse: (re)start a fade from the current level
//   fade_dir_i    0 = toward FADE_MAX (fade out), 1 = toward 0 (fade in)
//   level_o       current fade level, 0..FADE_MAX
//   state_o       FSM state (IDLE / FADING)
// ---------------------------------------------------------------------------
module palette_fade_ctrl
   import sprite_palette_pkg::*;
#(
   parameter int FADE_PERIOD = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        frame_tick_i,
   input  logic        fade_start_i,
   input  logic        fade_dir_i,
   output logic [4:0]  level_o,
   output fade_state_t state_o
);

   localparam int TW = (FADE_PERIOD > 1) ? $clog2(FADE_PERIOD) : 1;
   localparam logic [4:0]    LVL_MAX  = 5'(FADE_MAX);
   localparam logic [TW-1:0] CNT_LAST = TW'(FADE_PERIOD - 1);

   fade_state_t   state_q, state_d;
   logic [4:0]    level_q, level_d;
   logic          dir_q, dir_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [4:0]    run_target;
   logic [4:0]    start_target;

   always_comb begin
      state_d      = state_q;
      level_d      = level_q;
      dir_d        = dir_q;
      cnt_d        = cnt_q;
      run_target   = dir_q ? 5'd0 : LVL_MAX;
      start_target = fade_dir_i ? 5'd0 : LVL_MAX;

      // A start pulse outranks a coincident frame tick: the tick is
      // swallowed and the period counter starts over.
      if (fade_start_i) begin
         dir_d = fade_dir_i;
         cnt_d = '0;
         if (level_q == start_target) begin
            state_d = IDLE;
         end else begin
            state_d = FADING;
         end
      end else if ((state_q == FADING) && frame_tick_i) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = dir_q ? (level_q - 5'd1) : (level_q + 5'd1);
            if (level_d == run_target) state_d = IDLE;
         end else begin
            cnt_d = cnt_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         level_q <= '0;
         dir_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign state_o = state_q;

endmodule

// File: rtl/sprite_palette_bank.sv
// ---------------------------------------------------------------------------
// sprite_palette_bank
//   Runtime-writable multi-bank colour palette with a 2-stage lookup
//   pipeline, per-bank colour cycling and a frame-synchronous fade.
// Ports:
//   Clk, Reset                   clock, synchronous active-high reset
//   rd_valid/rd_bank/rd_index    lookup request
//   out_valid                    rd_valid delayed by 2 cycles
//   out_red/green/blue           faded colour (held while out_valid=0)
//   out_transparent              delayed rd_index==0 flag (never faded)
//   wr_en/wr_bank/wr_index/wr_rgb  palette write, {r,g,b}
//   frame_tick                   one pulse per frame
//   cyc_en/cyc_bank/cyc_lo/cyc_hi  colour-cycle control, inclusive range
//   fade_start/fade_dir          fade control; fade_busy while fading
// Handshake: a request is accepted on every edge where rd_valid=1 (no
//   back-pressure); its result appears with out_valid=1 exactly two edges
//   later. Reset drops every request still in the pipeline.
// ---------------------------------------------------------------------------
module sprite_palette_bank
   import sprite_palette_pkg::*;
#(
   parameter  int BANKS       = 4,
   parameter  int ENTRIES     = 8,
   parameter  int CW          = 4,
   parameter  int CYC_PERIOD  = 8,
   parameter  int FADE_PERIOD = 2,
   localparam int BW          = $clog2(BANKS),
   localparam int IW          = $clog2(ENTRIES)
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            rd_valid,
   input  logic [BW-1:0]   rd_bank,
   input  logic [IW-1:0]   rd_index,
   output logic            out_valid,
   output logic [CW-1:0]   out_red,
   output logic [CW-1:0]   out_green,
   output logic [CW-1:0]   out_blue,
   output logic            out_transparent,
   input  logic            wr_en,
   input  logic [BW-1:0]   wr_bank,
   input  logic [IW-1:0]   wr_index,
   input  logic [3*CW-1:0] wr_rgb,
   input  logic            frame_tick,
   input  logic            cyc_en,
   input  logic [BW-1:0]   cyc_bank,
   input  logic [IW-1:0]   cyc_lo,
   input  logic [IW-1:0]   cyc_hi,
   input  logic            fade_start,
   input  logic            fade_dir,
   output logic            fade_busy
);

   localparam int CTW = (CYC_PERIOD > 1) ? $clog2(CYC_PERIOD) : 1;
   localparam logic [CTW-1:0] CYC_LAST = CTW'(CYC_PERIOD - 1);

   // ---------------- palette storage ----------------
   logic [3*CW-1:0] pal_q [BANKS][ENTRIES];

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int b = 0; b < BANKS; b++) begin
            for (int e = 0; e < ENTRIES; e++) begin
               pal_q[b][e] <= (b == 0) ? default_entry(e) : '0;
            end
         end
      end else if (wr_en) begin
         pal_q[wr_bank][wr_index] <= wr_rgb;
      end
   end

   // ---------------- colour cycling ----------------
   logic [IW-1:0]  cyc_off_q, cyc_off_d;
   logic [CTW-1:0] cyc_cnt_q, cyc_cnt_d;
   logic [IW:0]    cyc_len;
   logic           cyc_range_ok;
   logic [IW:0]    off_base;
   logic [IW:0]    off_next;

   assign cyc_len      = {1'b0, cyc_hi} - {1'b0, cyc_lo} + (IW+1)'(1);
   assign cyc_range_ok = (cyc_lo < cyc_hi);

   always_comb begin
      cyc_off_d = cyc_off_q;
      cyc_cnt_d = cyc_cnt_q;
      off_base  = '0;
      off_next  = '0;
      if (!cyc_en) begin
         cyc_off_d = '0;
         cyc_cnt_d = '0;
      end else if (frame_tick) begin
         if (cyc_cnt_q == CYC_LAST) begin
            cyc_cnt_d = '0;
            if (!cyc_range_ok) begin
               cyc_off_d = '0;
            end else begin
               // An offset left over from a wider range restarts at 0.
               off_base = ({1'b0, cyc_off_q} >= cyc_len) ? '0 : {1'b0, cyc_off_q};
               off_next = off_base + (IW+1)'(1);
               if (off_next >= cyc_len) off_next = '0;
               cyc_off_d = IW'(off_next);
            end
         end else begin
            cyc_cnt_d = cyc_cnt_q + CTW'(1);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         cyc_off_q <= '0;
         cyc_cnt_q <= '0;
      end else begin
         cyc_off_q <= cyc_off_d;
         cyc_cnt_q <= cyc_cnt_d;
      end
   end

   // ---------------- S1: index remap and array read ----------------
   logic [IW-1:0] eidx;
   logic [IW:0]   rel;
   logic [IW:0]   rot_sum;

   always_comb begin
      eidx    = rd_index;
      rel     = '0;
      rot_sum = '0;
      if (cyc_en && (rd_bank == cyc_bank) && cyc_range_ok &&
          (rd_index >= cyc_lo) && (rd_index <= cyc_hi)) begin
         rel     = {1'b0, rd_index} - {1'b0, cyc_lo};
         rot_sum = rel + {1'b0, cyc_off_q};
         eidx    = cyc_lo + IW'(rot_sum % cyc_len);
      end
   end

   logic            s1_valid_q;
   logic [3*CW-1:0] s1_rgb_q;
   logic            s1_transp_q;

   // The array is sampled before this edge's write lands, so a read and
   // write to the same address in one cycle returns the old colour.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1_valid_q  <= 1'b0;
         s1_rgb_q    <= '0;
         s1_transp_q <= 1'b0;
      end else begin
         s1_valid_q <= rd_valid;
         if (rd_valid) begin
            s1_rgb_q    <= pal_q[rd_bank][eidx];
            s1_transp_q <= (rd_index == '0);
         end
      end
   end

   // ---------------- fade controller ----------------
   logic [4:0]  fade_level;
   fade_state_t fade_state;

   palette_fade_ctrl #(
      .FADE_PERIOD (FADE_PERIOD)
   ) u_fade (
      .clk_i        (Clk),
      .rst_i        (Reset),
      .frame_tick_i (frame_tick),
      .fade_start_i (fade_start),
      .fade_dir_i   (fade_dir),
      .level_o      (fade_level),
      .state_o      (fade_state)
   );

   assign fade_busy = (fade_state == FADING);

   // ---------------- S2: fade scaling and output ----------------
   logic [4:0] fade_scale;
   assign fade_scale = 5'(FADE_MAX) - fade_level;

   // (c * scale) >> 4 in a CW+5 bit product; scale=16 is identity, 0 is black.
   function automatic logic [CW-1:0] fade_ch(input logic [CW-1:0] c,
                                             input logic [4:0]    scale);
      return CW'(({5'b0, c} * {{CW{1'b0}}, scale}) >> 4);
   endfunction

   logic          out_valid_q;
   logic [CW-1:0] out_r_q, out_g_q, out_b_q;
   logic          out_transp_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         out_valid_q  <= 1'b0;
         out_r_q      <= '0;
         out_g_q      <= '0;
         out_b_q      <= '0;
         out_transp_q <= 1'b0;
      end else begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_r_q      <= fade_ch(s1_rgb_q[3*CW-1:2*CW], fade_scale);
            out_g_q      <= fade_ch(s1_rgb_q[2*CW-1:CW],   fade_scale);
            out_b_q      <= fade_ch(s1_rgb_q[CW-1:0],      fade_scale);
            out_transp_q <= s1_transp_q;
         end
      end
   end

   assign out_valid       = out_valid_q;
   assign out_red         = out_r_q;
   assign out_green       = out_g_q;
   assign out_blue        = out_b_q;
   assign out_transparent = out_transp_q;

endmodule

// File: tb/tb_sprite_palette_bank.sv
// ---------------------------------------------------------------------------
// tb_sprite_palette_bank
//   Self-checking bench for sprite_palette_bank with a behavioural model:
//   palette contents in an array, cycle offset from tick counts, fade level
//   from tick counts, fade arithmetic in plain integer math.
// ---------------------------------------------------------------------------
module tb_sprite_palette_bank;

   localparam int CYC_PERIOD  = 8;
   localparam int FADE_PERIOD = 2;

   // ---------------- clock / reset ----------------
   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        rd_valid = 1'b0;
   logic [1:0]  rd_bank = '0;
   logic [2:0]  rd_index = '0;
   logic        out_valid;
   logic [3:0]  out_red, out_green, out_blue;
   logic        out_transparent;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_bank = '0;
   logic [2:0]  wr_index = '0;
   logic [11:0] wr_rgb = '0;
   logic        frame_tick = 1'b0;
   logic        cyc_en = 1'b0;
   logic [1:0]  cyc_bank = '0;
   logic [2:0]  cyc_lo = '0;
   logic [2:0]  cyc_hi = '0;
   logic        fade_start = 1'b0;
   logic        fade_dir = 1'b0;
   logic        fade_busy;

   always #5 Clk = ~Clk;

   sprite_palette_bank dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .rd_valid        (rd_valid),
      .rd_bank         (rd_bank),
      .rd_index        (rd_index),
      .out_valid       (out_valid),
      .out_red         (out_red),
      .out_green       (out_green),
      .out_blue        (out_blue),
      .out_transparent (out_transparent),
      .wr_en           (wr_en),
      .wr_bank         (wr_bank),
      .wr_index        (wr_index),
      .wr_rgb          (wr_rgb),
      .frame_tick      (frame_tick),
      .cyc_en          (cyc_en),
      .cyc_bank        (cyc_bank),
      .cyc_lo          (cyc_lo),
      .cyc_hi          (cyc_hi),
      .fade_start      (fade_start),
      .fade_dir        (fade_dir),
      .fade_busy       (fade_busy)
   );

   // ---------------- model and scoreboard ----------------
   int errors = 0;
   int checks = 0;
   logic [11:0] pal_m [4][8];
   logic [12:0] exp_q [$];
   localparam logic [11:0] DEF_TBL [8] = '{
      12'h050, 12'hEA2, 12'h860, 12'h090, 12'h7C0, 12'h420, 12'h000, 12'h5A0
   };

   function automatic logic [11:0] fade_rgb(input logic [11:0] c, input int lvl);
      int r, g, b;
      r = int'(c[11:8]) * (16 - lvl) / 16;
      g = int'(c[7:4])  * (16 - lvl) / 16;
      b = int'(c[3:0])  * (16 - lvl) / 16;
      return {r[3:0], g[3:0], b[3:0]};
   endfunction

   function automatic int exp_eidx(input int i, input int lo, input int hi, input int off);
      if (lo < hi && i >= lo && i <= hi) return lo + ((i - lo + off) % (hi - lo + 1));
      return i;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 4; b++)
         for (int e = 0; e < 8; e++)
            pal_m[b][e] = (b == 0) ? DEF_TBL[e] : 12'h000;
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      step();
      step();
      Reset = 1'b0;
      model_reset();
   endtask

   task automatic lookup(input int b, input int i, output logic v,
                         output logic [11:0] rgb, output logic tr);
      rd_valid = 1'b1;
      rd_bank  = b[1:0];
      rd_index = i[2:0];
      step();
      rd_valid = 1'b0;
      step();
      v   = out_valid;
      rgb = {out_red, out_green, out_blue};
      tr  = out_transparent;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      checks++;
      if ({out_red, out_green, out_blue, out_transparent} !== 13'h0) begin
         errors++; $display("FAIL reset_outputs: got %h/%b want 000/0",
                            {out_red, out_green, out_blue}, out_transparent);
      end
      checks++;
      if (fade_busy !== 1'b0) begin
         errors++; $display("FAIL reset_fade_busy: got %b want 0", fade_busy);
      end
   endtask

   task automatic test_default_read();
      logic v, tr;
      logic [11:0] rgb;
      for (int i = 0; i < 2; i++) begin
         lookup(0, 1 - i, v, rgb, tr);
         checks++;
         if (v !== 1'b1 || rgb !== pal_m[0][1-i] || tr !== (i == 1)) begin
            errors++; $display("FAIL default_read idx%0d: got v=%b rgb=%h tr=%b want rgb=%h tr=%b",
                               1 - i, v, rgb, tr, pal_m[0][1-i], i == 1);
         end
      end
   endtask

   task automatic test_write_rbw();
      logic v, tr;
      logic [11:0] rgb;
      logic [11:0] old_rgb;
      old_rgb  = pal_m[2][3];
      wr_en    = 1'b1; wr_bank = 2'd2; wr_index = 3'd3; wr_rgb = 12'hF0F;
      rd_valid = 1'b1; rd_bank = 2'd2; rd_index = 3'd3;
      step();
      wr_en = 1'b0; rd_valid = 1'b0;
      pal_m[2][3] = 12'hF0F;
      step();
      checks++;
      if (out_valid !== 1'b1 || {out_red, out_green, out_blue} !== old_rgb) begin
         errors++; $display("FAIL rbw_same_cycle: got v=%b rgb=%h want rgb=%h",
                            out_valid, {out_red, out_green, out_blue}, old_rgb);
      end
      lookup(2, 3, v, rgb, tr);
      checks++;
      if (v !== 1'b1 || rgb !== pal_m[2][3] || tr !== 1'b0) begin
         errors++; $display("FAIL rbw_next_read: got v=%b rgb=%h tr=%b want rgb=%h tr=0",
                            v, rgb, tr, pal_m[2][3]);
      end
   endtask

   task automatic test_back_to_back();
      int seen, first, last;
      logic [12:0] e;
      seen = 0; first = -1; last = -1;
      step(); step();
      for (int k = 0; k < 12; k++) begin
         if (out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL b2b_unexpected: out_valid with empty queue at cycle %0d", k);
            end else begin
               e = exp_q.pop_front();
               if ({out_transparent, out_red, out_green, out_blue} !== e) begin
                  errors++; $display("FAIL b2b_data: got %h want %h",
                                     {out_transparent, out_red, out_green, out_blue}, e);
               end
            end
            seen++;
            if (first < 0) first = k;
            last = k;
         end
         if (k < 8) begin
            rd_valid = 1'b1; rd_bank = 2'd0; rd_index = k[2:0];
            exp_q.push_back({k == 0, pal_m[0][k]});
         end else begin
            rd_valid = 1'b0;
         end
         step();
      end
      checks++;
      if (seen != 8 || (last - first) != 7 || exp_q.size() != 0) begin
         errors++; $display("FAIL b2b_stream: got %0d valids over %0d cycles want 8 over 8",
                            seen, last - first + 1);
      end
      exp_q.delete();
   endtask

   task automatic test_cycle_directed();
      logic v, tr;
      logic [11:0] rgb;
      cyc_bank = 2'd0; cyc_lo = 3'd2; cyc_hi = 3'd4; cyc_en = 1'b1;
      ticks(CYC_PERIOD);
      lookup(0, 4, v, rgb, tr);
      checks++;
      if (v !== 1'b1 || rgb !== pal_m[0][2]) begin
         errors++; $display("FAIL cyc_off1_idx4: got %h want %h", rgb, pal_m[0][2]);
      end
      lookup(0, 2, v, rgb, tr);
      checks++;
      if (v !== 1'b1 || rgb !== pal_m[0][3]) begin
         errors++; $display("FAIL cyc_off1_idx2: got %h want %h", rgb, pal_m[0][3]);
      end
      lookup(0, 5, v, rgb, tr);
      checks++;
      if (v !== 1'b1 || rgb !== pal_m[0][5]) begin
         errors++; $display("FAIL cyc_idx5_untouched: got %h want %h", rgb, pal_m[0][5]);
      end
      ticks(2 * CYC_PERIOD);
      lookup(0, 4, v, rgb, tr);
      checks++;
      if (v !== 1'b1 || rgb !== pal_m[0][4]) begin
         errors++; $display("FAIL cyc_wrap_idx4: got %h want %h", rgb, pal_m[0][4]);
      end
      cyc_en = 1'b0;
      step();
   endtask

   task automatic test_fade_out();
      logic v, tr;
      logic [11:0] rgb;
      fade_dir = 1'b0; fade_start = 1'b1;
      step();
      fade_start = 1'b0;
      checks++;
      if (fade_busy !== 1'b1) begin
         errors++; $display("FAIL fade_start_busy: got %b want 1", fade_busy);
      end
      ticks(8 * FADE_PERIOD);
      lookup(0, 1, v, rgb, tr);
      checks++;
      if (v !== 1'b1 || rgb !== fade_rgb(pal_m[0][1], 8) || tr !== 1'b0) begin
         errors++; $display("FAIL fade_level8: got %h want %h", rgb, fade_rgb(pal_m[0][1], 8));
      end
      ticks(8 * FADE_PERIOD);
      lookup(0, 1, v, rgb, tr);
      checks++;
      if (v !== 1'b1 || rgb !== fade_rgb(pal_m[0][1], 16) || fade_busy !== 1'b0) begin
         errors++; $display("FAIL fade_level16: got %h busy=%b want %h busy=0",
                            rgb, fade_busy, fade_rgb(pal_m[0][1], 16));
      end
      lookup(0, 0, v, rgb, tr);
      checks++;
      if (tr !== 1'b1 || rgb !== 12'h000) begin
         errors++; $display("FAIL fade_transparent: got tr=%b rgb=%h want tr=1 rgb=000", tr, rgb);
      end
      fade_dir = 1'b0; fade_start = 1'b1;
      step();
      fade_start = 1'b0;
      checks++;
      if (fade_busy !== 1'b0) begin
         errors++; $display("FAIL fade_at_target: got busy=%b want 0", fade_busy);
      end
   endtask

   task automatic test_fade_reverse();
      logic v, tr;
      logic [11:0] rgb;
      do_reset();
      fade_dir = 1'b1; fade_start = 1'b1;
      step();
      fade_start = 1'b0;
      checks++;
      if (fade_busy !== 1'b0) begin
         errors++; $display("FAIL fade_in_at_zero: got busy=%b want 0", fade_busy);
      end
      fade_dir = 1'b0; fade_start = 1'b1;
      step();
      fade_start = 1'b0;
      ticks(10 * FADE_PERIOD);
      lookup(0, 1, v, rgb, tr);
      checks++;
      if (v !== 1'b1 || rgb !== fade_rgb(pal_m[0][1], 10)) begin
         errors++; $display("FAIL fade_level10: got %h want %h", rgb, fade_rgb(pal_m[0][1], 10));
      end
      // Reverse with a coincident tick: the tick must not count.
      fade_dir = 1'b1; fade_start = 1'b1; frame_tick = 1'b1;
      step();
      fade_start = 1'b0; frame_tick = 1'b0;
      step();
      ticks(3);
      lookup(0, 1, v, rgb, tr);
      checks++;
      if (v !== 1'b1 || rgb !== fade_rgb(pal_m[0][1], 9) || fade_busy !== 1'b1) begin
         errors++; $display("FAIL fade_reverse_level9: got %h busy=%b want %h busy=1",
                            rgb, fade_busy, fade_rgb(pal_m[0][1], 9));
      end
   endtask

   task automatic test_reset_mid();
      logic v, tr;
      logic [11:0] rgb;
      rd_valid = 1'b1; rd_bank = 2'd0; rd_index = 3'd1;
      step();
      rd_valid = 1'b0; Reset = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0 || fade_busy !== 1'b0 ||
          {out_red, out_green, out_blue, out_transparent} !== 13'h0) begin
         errors++; $display("FAIL reset_mid: got v=%b busy=%b rgb=%h want v=0 busy=0 rgb=000",
                            out_valid, fade_busy, {out_red, out_green, out_blue});
      end
      Reset = 1'b0;
      model_reset();
      step();
      lookup(0, 1, v, rgb, tr);
      checks++;
      if (v !== 1'b1 || rgb !== pal_m[0][1]) begin
         errors++; $display("FAIL reset_mid_level0: got %h want %h", rgb, pal_m[0][1]);
      end
   endtask

   task automatic test_random_rw();
      logic [12:0] e;
      int b, i;
      step(); step();
      for (int k = 0; k < 203; k++) begin
         if (out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL rand_unexpected: out_valid with empty queue at cycle %0d", k);
            end else begin
               e = exp_q.pop_front();
               if ({out_transparent, out_red, out_green, out_blue} !== e) begin
                  errors++; $display("FAIL rand_data: cycle %0d got %h want %h", k,
                                     {out_transparent, out_red, out_green, out_blue}, e);
               end
            end
         end
         rd_valid = 1'b0; wr_en = 1'b0;
         if (k < 200) begin
            b = $urandom_range(0, 3); i = $urandom_range(0, 7);
            rd_valid = ($urandom_range(0, 3) != 0);
            rd_bank = b[1:0]; rd_index = i[2:0];
            if (rd_valid) exp_q.push_back({i == 0, pal_m[b][i]});
            b = $urandom_range(0, 3); i = $urandom_range(0, 7);
            wr_en = $urandom_range(0, 1) == 1;
            wr_bank = b[1:0]; wr_index = i[2:0]; wr_rgb = 12'($urandom_range(0, 4095));
            if (wr_en) pal_m[b][i] = wr_rgb;
         end
         step();
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL rand_drain: %0d results missing want 0", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_cycle_random();
      logic v, tr;
      logic [11:0] rgb, want;
      int cb, lo, hi, n, off, ei;
      for (int t = 0; t < 8; t++) begin
         cyc_en = 1'b0;
         step();
         cb = $urandom_range(0, 3); lo = $urandom_range(0, 7); hi = $urandom_range(0, 7);
         if (t == 7) hi = lo;
         cyc_bank = cb[1:0]; cyc_lo = lo[2:0]; cyc_hi = hi[2:0]; cyc_en = 1'b1;
         n = $urandom_range(0, 40);
         ticks(n);
         off = (lo < hi) ? (n / CYC_PERIOD) % (hi - lo + 1) : 0;
         for (int i = 0; i < 8; i++) begin
            ei = exp_eidx(i, lo, hi, off);
            want = pal_m[cb][ei];
            lookup(cb, i, v, rgb, tr);
            checks++;
            if (v !== 1'b1 || rgb !== want || tr !== (i == 0)) begin
               errors++; $display("FAIL cyc_rand b%0d lo%0d hi%0d n%0d idx%0d: got %h tr=%b want %h tr=%b",
                                  cb, lo, hi, n, i, rgb, tr, want, i == 0);
            end
         end
      end
      cyc_en = 1'b0;
      step();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      do_reset();
      test_reset();
      test_default_read();
      test_write_rbw();
      test_back_to_back();
      test_cycle_directed();
      test_fade_out();
      test_fade_reverse();
      test_reset_mid();
      test_random_rw();
      test_cycle_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
